// File: rtl/show_sequencer.sv
// show_sequencer
//   Controller side of the LED light-show frame interface. Conditions the
//   start button, paces the show with a frame timer, issues one-cycle
//   frame-advance pulses to the pattern generator, counts completed loops
//   and drives three active-low 7-segment digits.
//
// Ports
//   clk       system clock
//   resetBtn  asynchronous active-low reset
//   startBtn  raw active-low push button (asynchronous to clk)
//   pauseSw   1 = hold the show
//   countIn   generator frame counter
//   repeatIn  generator remaining-repeat count
//   enable    frame-advance pulse, one cycle wide
//   running   1 while the show is running
//   done      1 once the generator has no repeats left
//   loops     completed loops since start, saturating at 15
//   hex0      repeatIn digit (dash when above 9)
//   hex1      countIn ones digit
//   hex2      countIn tens digit (blank when 0)
module show_sequencer #(
  parameter int TICKS_PER_FRAME = 5000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LAST_FRAME      = 44
) (
  input  logic       clk,
  input  logic       resetBtn,
  input  logic       startBtn,
  input  logic       pauseSw,
  input  logic [5:0] countIn,
  input  logic [3:0] repeatIn,
  output logic       enable,
  output logic       running,
  output logic       done,
  output logic [3:0] loops,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2
);

  localparam logic [23:0] TIMER_LAST = 24'(TICKS_PER_FRAME - 1);
  localparam logic [19:0] DB_LAST    = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]  FRAME_LAST = 6'(LAST_FRAME);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t      state;
  logic        sync_p0;
  logic        sync_p1;
  logic        stable;
  logic [19:0] db_cnt;
  logic        press;
  logic [23:0] timer;
  logic        pause_by_sw;
  logic [5:0]  count_p1;
  logic        frame_due;
  logic        loop_end;
  logic [3:0]  tens;
  logic [3:0]  ones;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

  // Stage p0/p1: two-flop synchroniser, then the debouncer. A level change
  // is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // press fires for one cycle on an accepted release->pressed change.
  always_ff @(posedge clk or negedge resetBtn) begin
    if (!resetBtn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      stable  <= 1'b1;
      db_cnt  <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= startBtn;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      if (sync_p1 != stable) begin
        if (db_cnt == DB_LAST) begin
          stable <= sync_p1;
          db_cnt <= '0;
          press  <= ~sync_p1;
        end else begin
          db_cnt <= db_cnt + 20'd1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign frame_due = (timer == TIMER_LAST);
  assign loop_end  = (count_p1 == FRAME_LAST) && (countIn == 6'd0);

  // Show controller. enable/running/done are registered. Pause requests are
  // checked before the frame pulse so a pause landing on a due frame wins;
  // the resume cycle advances the timer, so a frame suppressed by the pause
  // is delivered on resume rather than lost or doubled.
  always_ff @(posedge clk or negedge resetBtn) begin
    if (!resetBtn) begin
      state       <= IDLE;
      timer       <= '0;
      loops       <= '0;
      count_p1    <= '0;
      pause_by_sw <= 1'b0;
      enable      <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      enable   <= 1'b0;
      count_p1 <= countIn;
      // Loops count in every state; a start press below overrides with a clear.
      if (loop_end && (loops != 4'hF))
        loops <= loops + 4'd1;

      case (state)
        IDLE: begin
          if (press) begin
            state   <= RUN;
            running <= 1'b1;
            timer   <= '0;
            loops   <= '0;
          end
        end
        RUN: begin
          if (repeatIn == 4'd0) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (pauseSw || press) begin
            state       <= PAUSE;
            running     <= 1'b0;
            pause_by_sw <= pauseSw;
          end else begin
            enable <= frame_due;
            timer  <= frame_due ? 24'd0 : timer + 24'd1;
          end
        end
        PAUSE: begin
          if (!pauseSw && (press || pause_by_sw)) begin
            state   <= RUN;
            running <= 1'b1;
            enable  <= frame_due;
            timer   <= frame_due ? 24'd0 : timer + 24'd1;
          end
        end
        DONE: begin
          if (press) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Display is purely combinational so it tracks the generator with no lag.
  assign tens = 4'(countIn / 6'd10);
  assign ones = 4'(countIn % 6'd10);

  always_comb begin
    hex0 = (repeatIn > 4'd9) ? SEG_DASH : seg7(repeatIn);
    hex1 = seg7(ones);
    hex2 = (tens == 4'd0) ? SEG_BLANK : seg7(tens);
  end

endmodule

// File: tb/tb_show_sequencer.sv
module tb_show_sequencer;

  logic       clk = 1'b0;
  logic       resetBtn;
  logic       startBtn;
  logic       pauseSw;
  logic [5:0] countIn;
  logic [3:0] repeatIn;
  logic       enable;
  logic       running;
  logic       done;
  logic [3:0] loops;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;

  int tests = 0;
  int fails = 0;
  int rises = 0;
  logic prev_run = 1'b0;

  show_sequencer #(
    .TICKS_PER_FRAME(4),
    .DEBOUNCE_CYCLES(3),
    .LAST_FRAME(44)
  ) dut (
    .clk(clk),
    .resetBtn(resetBtn),
    .startBtn(startBtn),
    .pauseSw(pauseSw),
    .countIn(countIn),
    .repeatIn(repeatIn),
    .enable(enable),
    .running(running),
    .done(done),
    .loops(loops),
    .hex0(hex0),
    .hex1(hex1),
    .hex2(hex2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_track;
    tick();
    if (running === 1'b1 && prev_run !== 1'b1) rises++;
    prev_run = running;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_btn;
    startBtn = 1'b0;
    repeat (8) tick();
    startBtn = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    resetBtn = 1'b0;
    startBtn = 1'b1;
    pauseSw  = 1'b0;
    countIn  = 6'd0;
    repeatIn = 4'd5;

    // Reset state
    repeat (3) tick();
    check("rst_enable", 32'(enable), 0);
    check("rst_running", 32'(running), 0);
    check("rst_done", 32'(done), 0);
    check("rst_loops", 32'(loops), 0);
    check("rst_hex0", 32'(hex0), 32'(7'b0010010));
    check("rst_hex1", 32'(hex1), 32'(7'b1000000));
    check("rst_hex2", 32'(hex2), 32'(7'b1111111));
    resetBtn = 1'b1;
    repeat (3) tick();
    check("idle_running", 32'(running), 0);

    // Clean press: running at raw edge + 6, then a pulse every 4 cycles
    startBtn = 1'b0;
    repeat (5) tick();
    check("press_lat5", 32'(running), 0);
    tick();
    check("press_lat6", 32'(running), 1);
    check("press_enable0", 32'(enable), 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("pulse_train", 32'(enable), (i == 4 || i == 8) ? 1 : 0);
      if (i == 4) startBtn = 1'b1;
    end

    // Pause by switch at timer=2, hold 20 cycles, release
    tick();
    tick();
    pauseSw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_enable", 32'(enable), 0);
      check("hold_running", 32'(running), 0);
    end
    pauseSw = 1'b0;
    tick();
    check("resume_running", 32'(running), 1);
    check("resume_enable0", 32'(enable), 0);
    tick();
    check("resume_pulse", 32'(enable), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("resume_gap", 32'(enable), 0);
    end
    tick();
    check("resume_pulse2", 32'(enable), 1);

    // Pause rising exactly when a pulse is due: pause wins
    repeat (3) tick();
    pauseSw = 1'b1;
    tick();
    check("pausewin_enable", 32'(enable), 0);
    check("pausewin_running", 32'(running), 0);
    tick();
    tick();
    pauseSw = 1'b0;
    tick();
    check("pausewin_deferred", 32'(enable), 1);
    check("pausewin_running1", 32'(running), 1);

    // Button toggles pause
    press_btn();
    check("btn_pause", 32'(running), 0);
    press_btn();
    check("btn_resume", 32'(running), 1);

    // Loop detection
    countIn = 6'd43; tick();
    countIn = 6'd44; tick();
    countIn = 6'd0;  tick();
    check("loops_1", 32'(loops), 1);
    countIn = 6'd1;  tick();
    countIn = 6'd44; tick();
    countIn = 6'd0;  tick();
    check("loops_2", 32'(loops), 2);
    countIn = 6'd10; tick();
    countIn = 6'd0;  tick();
    check("loops_nowrap", 32'(loops), 2);

    // Show end
    repeatIn = 4'd1;
    tick();
    check("rep1_running", 32'(running), 1);
    repeatIn = 4'd0;
    tick();
    check("done_done", 32'(done), 1);
    check("done_running", 32'(running), 0);
    check("done_enable", 32'(enable), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("done_noenable", 32'(enable), 0);
    end
    check("hex0_zero", 32'(hex0), 32'(7'b1000000));
    repeatIn = 4'd12;
    #1;
    check("hex0_dash", 32'(hex0), 32'(7'b0111111));

    // Display decode
    countIn  = 6'd37;
    repeatIn = 4'd9;
    #1;
    check("hex2_3", 32'(hex2), 32'(7'b0110000));
    check("hex1_7", 32'(hex1), 32'(7'b1111000));
    check("hex0_9", 32'(hex0), 32'(7'b0010000));
    countIn = 6'd5;
    #1;
    check("hex2_blank", 32'(hex2), 32'(7'b1111111));
    check("hex1_5", 32'(hex1), 32'(7'b0010010));
    countIn = 6'd50;
    #1;
    check("hex2_5", 32'(hex2), 32'(7'b0010010));
    check("hex1_0", 32'(hex1), 32'(7'b1000000));

    // DONE -> IDLE on press
    press_btn();
    check("idle_done", 32'(done), 0);
    check("idle_running2", 32'(running), 0);

    // Bouncing button from IDLE: one accepted press
    prev_run = running;
    rises = 0;
    startBtn = 1'b0; tick_track();
    startBtn = 1'b1; tick_track();
    startBtn = 1'b0; tick_track();
    startBtn = 1'b1; tick_track();
    startBtn = 1'b0;
    repeat (12) tick_track();
    startBtn = 1'b1;
    repeat (8) tick_track();
    check("bounce_rises", rises, 1);
    check("bounce_running", 32'(running), 1);
    check("bounce_loops_clr", 32'(loops), 0);

    // Async reset mid-RUN while enable is high
    countIn = 6'd44; tick();
    countIn = 6'd0;  tick();
    check("loops_before_rst", 32'(loops), 1);
    begin
      int waited = 0;
      while (enable !== 1'b1 && waited < 8) begin
        tick();
        waited++;
      end
    end
    check("enable_seen", 32'(enable), 1);
    resetBtn = 1'b0;
    #1;
    check("async_enable", 32'(enable), 0);
    check("async_running", 32'(running), 0);
    check("async_loops", 32'(loops), 0);
    tick();
    resetBtn = 1'b1;
    tick();
    check("post_rst_enable", 32'(enable), 0);
    check("post_rst_running", 32'(running), 0);

    // repeatIn==0 in IDLE: RUN for one cycle, then DONE, no pulses
    repeatIn = 4'd0;
    startBtn = 1'b0;
    repeat (5) tick();
    check("rep0_lat5", 32'(running), 0);
    tick();
    check("rep0_run", 32'(running), 1);
    check("rep0_enable_a", 32'(enable), 0);
    tick();
    check("rep0_done", 32'(done), 1);
    check("rep0_running0", 32'(running), 0);
    check("rep0_enable_b", 32'(enable), 0);
    startBtn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rep0_noenable", 32'(enable), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
